// File: rtl/r4_ctrl_pkg.sv
// Shared types and opcode constants for the R4 multi-cycle control path.
package r4_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StError,
        StTrap
    } state_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2,
        PC_TRAP  = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_a_sel_e;

    typedef enum logic [3:0] {
        ClsOp,
        ClsOpImm,
        ClsLui,
        ClsAuipc,
        ClsJal,
        ClsJalr,
        ClsBranch,
        ClsLoad,
        ClsStore,
        ClsNop,
        ClsIllegal
    } instr_cls_e;

    localparam logic [6:0] OP_LOAD     = 7'h03;
    localparam logic [6:0] OP_MISC_MEM = 7'h0F;
    localparam logic [6:0] OP_OP_IMM   = 7'h13;
    localparam logic [6:0] OP_AUIPC    = 7'h17;
    localparam logic [6:0] OP_STORE    = 7'h23;
    localparam logic [6:0] OP_OP       = 7'h33;
    localparam logic [6:0] OP_LUI      = 7'h37;
    localparam logic [6:0] OP_BRANCH   = 7'h63;
    localparam logic [6:0] OP_JALR     = 7'h67;
    localparam logic [6:0] OP_JAL      = 7'h6F;
    localparam logic [6:0] OP_SYSTEM   = 7'h73;

    function automatic imm_sel_e cls_imm_sel(input instr_cls_e cls);
        imm_sel_e sel;
        sel = IMM_I;
        unique case (cls)
            ClsStore:         sel = IMM_S;
            ClsBranch:        sel = IMM_B;
            ClsLui, ClsAuipc: sel = IMM_U;
            ClsJal:           sel = IMM_J;
            default:          sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: instruction class and immediate format.
module ctrl_decode
    import r4_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output instr_cls_e o_cls,
    output imm_sel_e   o_imm_sel
);

    always_comb begin
        o_cls = ClsIllegal;
        case (i_opcode)
            OP_LOAD:     o_cls = ClsLoad;
            OP_STORE:    o_cls = ClsStore;
            OP_OP:       o_cls = ClsOp;
            OP_OP_IMM:   o_cls = ClsOpImm;
            OP_LUI:      o_cls = ClsLui;
            OP_AUIPC:    o_cls = ClsAuipc;
            OP_JAL:      o_cls = ClsJal;
            OP_JALR:     o_cls = ClsJalr;
            OP_BRANCH:   o_cls = ClsBranch;
            OP_MISC_MEM: o_cls = ClsNop;
            OP_SYSTEM:   o_cls = ClsNop;
            default:     o_cls = ClsIllegal;
        endcase
        o_imm_sel = cls_imm_sel(o_cls);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the R4 multi-cycle RV32I core.
// Optional build macro MULTICYCLE_CTRL_TRAP_EN routes unknown opcodes to a trap state.
module multicycle_ctrl
    import r4_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RET_CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           i_opcode,
    input  logic [2:0]           i_funct3,
    input  logic                 i_br_taken,
    input  logic                 i_mem_ready,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic                 o_addr_sel,
    output logic                 o_ir_we,
    output logic                 o_pc_we,
    output logic [1:0]           o_pc_sel,
    output logic [2:0]           o_imm_sel,
    output logic [1:0]           o_alu_a_sel,
    output logic                 o_alu_b_sel,
    output logic                 o_rf_we,
    output logic [1:0]           o_wb_sel,
    output logic [RET_CNT_W-1:0] o_retired,
    output logic                 o_err,
    output logic                 o_trap
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    state_e               r_state;
    logic [RET_CNT_W-1:0] r_retired;
    logic [WAIT_W-1:0]    r_wait;

    instr_cls_e  w_cls;
    imm_sel_e    w_imm_sel;
    alu_a_sel_e  w_alu_a;
    logic        w_alu_b;
    logic        w_waiting;
    logic        w_timeout;
    logic        w_retire;
    logic        w_exec_done;
    logic [WAIT_W-1:0] w_wait_inc;
    logic        w_unused_funct3;

    assign w_unused_funct3 = ^i_funct3;

    ctrl_decode u_decode (
        .i_opcode  (i_opcode),
        .o_cls     (w_cls),
        .o_imm_sel (w_imm_sel)
    );

    // Classes that finish in EXEC without touching memory or the regfile.
    assign w_exec_done = (w_cls == ClsBranch) || (w_cls == ClsNop) || (w_cls == ClsIllegal);

    assign w_waiting  = o_mem_req && !i_mem_ready;
    assign w_wait_inc = r_wait + WAIT_W'(1);
    assign w_timeout  = (MEM_TIMEOUT != 0) && w_waiting && (w_wait_inc == TIMEOUT_CNT);

    assign w_retire = ((r_state == StExec) && w_exec_done)
                   || ((r_state == StMem) && i_mem_ready && (w_cls == ClsStore))
                   || (r_state == StWb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StFetch;
            r_retired <= '0;
            r_wait    <= '0;
        end else begin
            unique case (r_state)
                StFetch: begin
                    if (i_mem_ready) r_state <= StDecode;
                end
`ifdef MULTICYCLE_CTRL_TRAP_EN
                StDecode: r_state <= (w_cls == ClsIllegal) ? StTrap : StExec;
`else
                StDecode: r_state <= StExec;
`endif
                StExec: begin
                    if ((w_cls == ClsLoad) || (w_cls == ClsStore)) begin
                        r_state <= StMem;
                    end else if (w_exec_done) begin
                        r_state <= StFetch;
                    end else begin
                        r_state <= StWb;
                    end
                end
                StMem: begin
                    if (i_mem_ready) r_state <= (w_cls == ClsStore) ? StFetch : StWb;
                end
                StWb:    r_state <= StFetch;
                StError: r_state <= StError;
                StTrap:  r_state <= StFetch;
                default: r_state <= StFetch;
            endcase

            if (w_timeout) r_state <= StError;

            r_wait <= (w_waiting && (MEM_TIMEOUT != 0)) ? w_wait_inc : '0;

            if (w_retire) r_retired <= r_retired + RET_CNT_W'(1);
        end
    end

    always_comb begin
        w_alu_a = ALU_A_RS1;
        w_alu_b = 1'b1;
        unique case (w_cls)
            ClsOp, ClsBranch, ClsNop, ClsIllegal: w_alu_b = 1'b0;
            ClsLui:                               w_alu_a = ALU_A_ZERO;
            ClsAuipc, ClsJal:                     w_alu_a = ALU_A_PC;
            default: ;
        endcase
    end

    // Gated by rst_n so an in-flight request drops the moment reset asserts.
    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_addr_sel  = 1'b0;
        o_ir_we     = 1'b0;
        o_pc_we     = 1'b0;
        o_pc_sel    = PC_PLUS4;
        o_imm_sel   = IMM_I;
        o_alu_a_sel = ALU_A_RS1;
        o_alu_b_sel = 1'b0;
        o_rf_we     = 1'b0;
        o_wb_sel    = WB_ALU;
        if (rst_n) begin
            unique case (r_state)
                StFetch: begin
                    o_mem_req = 1'b1;
                    o_ir_we   = i_mem_ready;
                end
                StDecode: o_imm_sel = w_imm_sel;
                StExec: begin
                    o_imm_sel   = w_imm_sel;
                    o_alu_a_sel = w_alu_a;
                    o_alu_b_sel = w_alu_b;
                    if (w_exec_done) begin
                        o_pc_we  = 1'b1;
                        o_pc_sel = ((w_cls == ClsBranch) && i_br_taken) ? PC_IMM : PC_PLUS4;
                    end
                end
                StMem: begin
                    o_imm_sel   = w_imm_sel;
                    o_alu_a_sel = w_alu_a;
                    o_alu_b_sel = w_alu_b;
                    o_mem_req   = 1'b1;
                    o_addr_sel  = 1'b1;
                    o_mem_we    = (w_cls == ClsStore);
                    o_pc_we     = (w_cls == ClsStore) && i_mem_ready;
                end
                StWb: begin
                    o_imm_sel   = w_imm_sel;
                    o_alu_a_sel = w_alu_a;
                    o_alu_b_sel = w_alu_b;
                    o_rf_we     = 1'b1;
                    o_pc_we     = 1'b1;
                    unique case (w_cls)
                        ClsJal: begin
                            o_pc_sel = PC_IMM;
                            o_wb_sel = WB_PC4;
                        end
                        ClsJalr: begin
                            o_pc_sel = PC_ALU;
                            o_wb_sel = WB_PC4;
                        end
                        ClsLoad: o_wb_sel = WB_LOAD;
                        default: ;
                    endcase
                end
                StTrap: begin
                    o_pc_we  = 1'b1;
                    o_pc_sel = PC_TRAP;
                end
                StError: ;
                default: ;
            endcase
        end
    end

    assign o_retired = r_retired;
    assign o_err     = (r_state == StError);
`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign o_trap    = rst_n && (r_state == StTrap);
`else
    assign o_trap    = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction vector table plus memory-wait corner cases.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'h13;
    logic [2:0]  funct3 = 3'd0;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, alu_b_sel, rf_we, err, trap;
    logic [1:0]  pc_sel, alu_a_sel, wb_sel;
    logic [2:0]  imm_sel;
    logic [31:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .RET_CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_opcode    (opcode),
        .i_funct3    (funct3),
        .i_br_taken  (br_taken),
        .i_mem_ready (mem_ready),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_addr_sel  (addr_sel),
        .o_ir_we     (ir_we),
        .o_pc_we     (pc_we),
        .o_pc_sel    (pc_sel),
        .o_imm_sel   (imm_sel),
        .o_alu_a_sel (alu_a_sel),
        .o_alu_b_sel (alu_b_sel),
        .o_rf_we     (rf_we),
        .o_wb_sel    (wb_sel),
        .o_retired   (retired),
        .o_err       (err),
        .o_trap      (trap)
    );

    typedef struct {
        logic [6:0] op;
        logic       br;
        int         cyc;
        logic [2:0] imm;
        logic [1:0] pcs;
        logic [1:0] wb;
        logic       rf;
        logic       mw;
        logic [1:0] a;
        logic       b;
        int         inc;
        logic       trp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH with zero-wait memory; ends in the next FETCH.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] ret0;
        int          cyc;
        logic [2:0]  imm_s;
        logic [1:0]  pcs_s, wb_s, a_s;
        logic        b_s, rf_seen, mw_seen, trap_seen, ir_s;
        cyc = 0; imm_s = '0; pcs_s = '0; wb_s = '0; a_s = '0; b_s = 1'b0;
        rf_seen = 1'b0; mw_seen = 1'b0; trap_seen = 1'b0; ir_s = 1'b0;
        opcode = v.op; br_taken = v.br; mem_ready = 1'b1;
        ret0 = retired;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) ir_s = ir_we;
            if (c == 2) imm_s = imm_sel;
            if (c == 3) begin
                a_s = alu_a_sel;
                b_s = alu_b_sel;
            end
            rf_seen   |= rf_we;
            mw_seen   |= mem_we;
            trap_seen |= trap;
            if (pc_we) begin
                cyc   = c;
                pcs_s = pc_sel;
                wb_s  = wb_sel;
            end
            tick();
            if (cyc != 0) break;
        end
        chk($sformatf("v%0d op%0h ir_we", idx, v.op), 32'(ir_s), 32'd1);
        chk($sformatf("v%0d op%0h cycles", idx, v.op), 32'(cyc), 32'(v.cyc));
        chk($sformatf("v%0d op%0h imm_sel", idx, v.op), 32'(imm_s), 32'(v.imm));
        chk($sformatf("v%0d op%0h pc_sel", idx, v.op), 32'(pcs_s), 32'(v.pcs));
        chk($sformatf("v%0d op%0h wb_sel", idx, v.op), 32'(wb_s), 32'(v.wb));
        chk($sformatf("v%0d op%0h rf_we", idx, v.op), 32'(rf_seen), 32'(v.rf));
        chk($sformatf("v%0d op%0h mem_we", idx, v.op), 32'(mw_seen), 32'(v.mw));
        chk($sformatf("v%0d op%0h alu_a", idx, v.op), 32'(a_s), 32'(v.a));
        chk($sformatf("v%0d op%0h alu_b", idx, v.op), 32'(b_s), 32'(v.b));
        chk($sformatf("v%0d op%0h trap", idx, v.op), 32'(trap_seen), 32'(v.trp));
        chk($sformatf("v%0d op%0h retired", idx, v.op), retired, ret0 + 32'(v.inc));
    endtask

    initial begin
        logic [31:0] ret0;
        //          op     br    cyc imm   pcs   wb    rf    mw    a     b     inc trap
        vecs[0]  = '{7'h13, 1'b0, 4, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1, 1'b0};
        vecs[1]  = '{7'h33, 1'b0, 4, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1, 1'b0};
        vecs[2]  = '{7'h37, 1'b0, 4, 3'd3, 2'd0, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, 1, 1'b0};
        vecs[3]  = '{7'h17, 1'b0, 4, 3'd3, 2'd0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1, 1, 1'b0};
        vecs[4]  = '{7'h6F, 1'b0, 4, 3'd4, 2'd1, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, 1, 1'b0};
        vecs[5]  = '{7'h67, 1'b0, 4, 3'd0, 2'd2, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, 1, 1'b0};
        vecs[6]  = '{7'h03, 1'b0, 5, 3'd0, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 1, 1'b0};
        vecs[7]  = '{7'h23, 1'b0, 4, 3'd1, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1, 1'b0};
        vecs[8]  = '{7'h63, 1'b1, 3, 3'd2, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1, 1'b0};
        vecs[9]  = '{7'h63, 1'b0, 3, 3'd2, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1, 1'b0};
        vecs[10] = '{7'h0F, 1'b0, 3, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1, 1'b0};
        vecs[11] = '{7'h73, 1'b0, 3, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1, 1'b0};
`ifdef MULTICYCLE_CTRL_TRAP_EN
        vecs[12] = '{7'h7F, 1'b0, 3, 3'd0, 2'd3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1'b1};
`else
        vecs[12] = '{7'h7F, 1'b0, 3, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1, 1'b0};
`endif

        // Reset with mem_ready high: nothing may be enabled.
        #12;
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset ir_we", 32'(ir_we), 32'd0);
        chk("reset pc_we", 32'(pc_we), 32'd0);
        chk("reset retired", retired, 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset trap", 32'(trap), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Load with three wait cycles in MEM.
        opcode = 7'h03; br_taken = 1'b0; mem_ready = 1'b1;
        ret0 = retired;
        @(negedge clk);
        chk("lw_wait fetch ir_we", 32'(ir_we), 32'd1);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("lw_wait imm_sel", 32'(imm_sel), 32'd0);
        tick();
        @(negedge clk);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("lw_wait mem_req c%0d", k), 32'(mem_req), 32'd1);
            chk($sformatf("lw_wait addr_sel c%0d", k), 32'(addr_sel), 32'd1);
            chk($sformatf("lw_wait mem_we c%0d", k), 32'(mem_we), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("lw_wait wb_sel", 32'(wb_sel), 32'd1);
        chk("lw_wait rf_we", 32'(rf_we), 32'd1);
        chk("lw_wait mem_req in wb", 32'(mem_req), 32'd0);
        tick();
        chk("lw_wait retired", retired, ret0 + 32'd1);

        // Reset asserted while a load waits in MEM.
        opcode = 7'h03; mem_ready = 1'b1;
        @(negedge clk);
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("midmem mem_req before reset", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midmem mem_req async", 32'(mem_req), 32'd0);
        chk("midmem addr_sel async", 32'(addr_sel), 32'd0);
        chk("midmem retired async", retired, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midmem fetch mem_req", 32'(mem_req), 32'd1);
        chk("midmem fetch addr_sel", 32'(addr_sel), 32'd0);
        chk("midmem fetch retired", retired, 32'd0);

        // Fetch never completes: ERROR after 16 waiting cycles.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c == 16) begin
                chk("timeout err c16", 32'(err), 32'd0);
                chk("timeout mem_req c16", 32'(mem_req), 32'd1);
            end
            if (c == 17) begin
                chk("timeout err c17", 32'(err), 32'd1);
                chk("timeout mem_req c17", 32'(mem_req), 32'd0);
            end
            tick();
        end
        mem_ready = 1'b1; opcode = 7'h13;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("error sticky err c%0d", c), 32'(err), 32'd1);
            chk($sformatf("error ir_we c%0d", c), 32'(ir_we), 32'd0);
            chk($sformatf("error pc_we c%0d", c), 32'(pc_we), 32'd0);
            chk($sformatf("error mem_req c%0d", c), 32'(mem_req), 32'd0);
            tick();
        end
        chk("error retired", retired, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("error cleared by reset", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
